per_req_rr_arb_mux: RTL and testbench

N-channel request multiplexer for the peripheral interconnect. It merges `N_CH` master request ports onto one slave request port. A rotating-pointer round-robin arbiter gives a fair grant, and a stall lock keeps the presented request stable. An optional registered output stage (`REG_OUT`) cuts the combinational path toward the slave. It replaces cascaded two-input muxes on peripheral request paths and reports the winning channel index so the response path can route back.

---
 rtl/per_req_rr_arb_mux.sv | 149 ++++++++++++++
 tb/tb_per_req_rr_arb_mux.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/per_req_rr_arb_mux.sv
// per_req_rr_arb_mux: N-channel round-robin request mux toward one slave.
// REG_OUT selects a registered output slice or a combinational path with stall lock.
module per_req_rr_arb_mux #(
  parameter int N_CH       = 4,
  parameter int ID_WIDTH   = 20,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter bit REG_OUT    = 1'b1,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_CH-1:0]                      data_req_i,
  input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      data_add_i,
  input  logic [N_CH-1:0]                      data_wen_i,
  input  logic [N_CH-1:0][5:0]                 data_atop_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0]      data_wdata_i,
  input  logic [N_CH-1:0][BE_WIDTH-1:0]        data_be_i,
  input  logic [N_CH-1:0][ID_WIDTH-1:0]        data_ID_i,
  output logic [N_CH-1:0]                      data_gnt_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [5:0]                           data_atop_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [ID_WIDTH-1:0]                  data_ID_o,
  output logic [CH_W-1:0]                      data_ch_o,
  input  logic                                 data_gnt_i
);

  logic            any_req;
  logic            fire;
  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_nxt;
  logic [CH_W-1:0] rr_win;
  logic [CH_W-1:0] win;

  assign any_req = |data_req_i;

  // Scan from ptr_q upward with explicit wrap; first requester wins
  always_comb begin
    int   idx;
    logic found;
    rr_win = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && data_req_i[idx]) begin
        found  = 1'b1;
        rr_win = CH_W'(idx);
      end
    end
  end

  assign ptr_nxt = (int'(win) >= N_CH - 1) ? '0 : win + 1'b1;

  // Pointer moves past the channel just accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr_q <= '0;
    else if (fire) ptr_q <= ptr_nxt;
  end

  // Grant goes only to the effective winner
  always_comb begin
    data_gnt_o      = '0;
    data_gnt_o[win] = fire;
  end

  if (REG_OUT) begin : g_reg
    logic                  valid_q;
    logic [CH_W-1:0]       ch_q;
    logic [ADDR_WIDTH-1:0] add_q;
    logic                  wen_q;
    logic [5:0]            atop_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [ID_WIDTH-1:0]   id_q;

    assign win  = rr_win;
    assign fire = any_req & (~valid_q | data_gnt_i);

    // Output slice: reload on accept, empty when drained without refill
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        ch_q    <= '0;
        add_q   <= '0;
        wen_q   <= 1'b0;
        atop_q  <= '0;
        wdata_q <= '0;
        be_q    <= '0;
        id_q    <= '0;
      end else if (fire) begin
        valid_q <= 1'b1;
        ch_q    <= rr_win;
        add_q   <= data_add_i[rr_win];
        wen_q   <= data_wen_i[rr_win];
        atop_q  <= data_atop_i[rr_win];
        wdata_q <= data_wdata_i[rr_win];
        be_q    <= data_be_i[rr_win];
        id_q    <= data_ID_i[rr_win];
      end else if (data_gnt_i) begin
        valid_q <= 1'b0;
      end
    end

    assign data_req_o   = valid_q;
    assign data_ch_o    = ch_q;
    assign data_add_o   = add_q;
    assign data_wen_o   = wen_q;
    assign data_atop_o  = atop_q;
    assign data_wdata_o = wdata_q;
    assign data_be_o    = be_q;
    assign data_ID_o    = id_q;
  end else begin : g_comb
    logic            lock_q;
    logic [CH_W-1:0] lock_ch_q;

    assign win  = lock_q ? lock_ch_q : rr_win;
    assign fire = any_req & data_gnt_i;

    // Freeze the presented channel while the slave stalls it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lock_q    <= 1'b0;
        lock_ch_q <= '0;
      end else if (any_req && !data_gnt_i) begin
        lock_q    <= 1'b1;
        lock_ch_q <= win;
      end else begin
        lock_q    <= 1'b0;
      end
    end

    assign data_req_o   = any_req;
    assign data_ch_o    = win;
    assign data_add_o   = data_add_i[win];
    assign data_wen_o   = data_wen_i[win];
    assign data_atop_o  = data_atop_i[win];
    assign data_wdata_o = data_wdata_i[win];
    assign data_be_o    = data_be_i[win];
    assign data_ID_o    = data_ID_i[win];
  end

endmodule

// File: tb/tb_per_req_rr_arb_mux.sv
// tb_per_req_rr_arb_mux: scoreboard bench for per_req_rr_arb_mux.
// Three instances: 4ch comb, 4ch registered, 3ch comb.
module tb_per_req_rr_arb_mux;

  localparam int AW = 32;
  localparam int IW = 20;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]         req4;
  logic [3:0][AW-1:0] add4;
  logic [3:0]         wen4;
  logic [3:0][5:0]    atop4;
  logic [3:0][DW-1:0] wd4;
  logic [3:0][BW-1:0] be4;
  logic [3:0][IW-1:0] id4;

  logic [2:0]         req3;
  logic [2:0][AW-1:0] add3;
  logic [2:0]         wen3;
  logic [2:0][5:0]    atop3;
  logic [2:0][DW-1:0] wd3;
  logic [2:0][BW-1:0] be3;
  logic [2:0][IW-1:0] id3;

  logic gnt0, gnt1, gnt3;

  logic [3:0]    g0, g1;
  logic [2:0]    g3;
  logic          r0, r1, r3;
  logic [AW-1:0] a0, a1, a3;
  logic          w0, w1, w3;
  logic [5:0]    t0, t1, t3;
  logic [DW-1:0] d0, d1, d3;
  logic [BW-1:0] b0, b1, b3;
  logic [IW-1:0] i0, i1, i3;
  logic [1:0]    c0, c1, c3;

  per_req_rr_arb_mux #(.N_CH(4), .REG_OUT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req4), .data_add_i(add4), .data_wen_i(wen4),
    .data_atop_i(atop4), .data_wdata_i(wd4), .data_be_i(be4),
    .data_ID_i(id4), .data_gnt_o(g0), .data_req_o(r0),
    .data_add_o(a0), .data_wen_o(w0), .data_atop_o(t0),
    .data_wdata_o(d0), .data_be_o(b0), .data_ID_o(i0),
    .data_ch_o(c0), .data_gnt_i(gnt0)
  );

  per_req_rr_arb_mux #(.N_CH(4), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req4), .data_add_i(add4), .data_wen_i(wen4),
    .data_atop_i(atop4), .data_wdata_i(wd4), .data_be_i(be4),
    .data_ID_i(id4), .data_gnt_o(g1), .data_req_o(r1),
    .data_add_o(a1), .data_wen_o(w1), .data_atop_o(t1),
    .data_wdata_o(d1), .data_be_o(b1), .data_ID_o(i1),
    .data_ch_o(c1), .data_gnt_i(gnt1)
  );

  per_req_rr_arb_mux #(.N_CH(3), .REG_OUT(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req3), .data_add_i(add3), .data_wen_i(wen3),
    .data_atop_i(atop3), .data_wdata_i(wd3), .data_be_i(be3),
    .data_ID_i(id3), .data_gnt_o(g3), .data_req_o(r3),
    .data_add_o(a3), .data_wen_o(w3), .data_atop_o(t3),
    .data_wdata_o(d3), .data_be_o(b3), .data_ID_o(i3),
    .data_ch_o(c3), .data_gnt_i(gnt3)
  );

  int n_cmp = 0;
  int n_err = 0;
  int q0[$];
  int q1[$];
  int q3[$];

  function automatic logic [AW-1:0] f_add(int c);
    return 32'h4000_000c + 32'(c) * 32'h100;
  endfunction
  function automatic logic [IW-1:0] f_id(int c);
    return 20'hab000 + 20'(c);
  endfunction
  function automatic logic [DW-1:0] f_wd(int c);
    return 32'hd000_0000 | 32'(c * 7);
  endfunction
  function automatic logic [10:0] f_misc(int c);
    logic       wen;
    logic [5:0] atop;
    logic [3:0] be;
    wen  = (c % 2) == 1;
    atop = 6'(c + 1);
    be   = 4'(1 << c);
    return {wen, atop, be};
  endfunction

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic sb_cmp(string tag, int c, logic [1:0] ch,
                        logic [AW-1:0] a, logic [IW-1:0] id,
                        logic [DW-1:0] d, logic [10:0] misc);
    chk({tag, "_ch"}, ch, c);
    chk({tag, "_add"}, a, f_add(c));
    chk({tag, "_id"}, id, f_id(c));
    chk({tag, "_wdata"}, d, f_wd(c));
    chk({tag, "_misc"}, misc, f_misc(c));
  endtask

  // Pop and compare on every slave-side transfer
  always @(negedge clk) begin
    if (r0 && gnt0) begin
      if (q0.size() == 0) chk("u0_sb_size", 0, 1);
      else sb_cmp("u0", q0.pop_front(), c0, a0, i0, d0, {w0, t0, b0});
    end
    if (r1 && gnt1) begin
      if (q1.size() == 0) chk("u1_sb_size", 0, 1);
      else sb_cmp("u1", q1.pop_front(), c1, a1, i1, d1, {w1, t1, b1});
    end
    if (r3 && gnt3) begin
      if (q3.size() == 0) chk("u3_sb_size", 0, 1);
      else sb_cmp("u3", q3.pop_front(), c3, a3, i3, d3, {w3, t3, b3});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req4 = '0;
    req3 = '0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    gnt3 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e4;
    req4 = '0;
    req3 = '0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    gnt3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      add4[c] = f_add(c);
      id4[c] = f_id(c);
      wd4[c] = f_wd(c);
      {wen4[c], atop4[c], be4[c]} = f_misc(c);
    end
    for (int c = 0; c < 3; c++) begin
      add3[c] = f_add(c);
      id3[c] = f_id(c);
      wd3[c] = f_wd(c);
      {wen3[c], atop3[c], be3[c]} = f_misc(c);
    end

    @(negedge clk);
    chk("rst_u0_req", r0, 0);
    chk("rst_u0_gnt", g0, 0);
    chk("rst_u1_req", r1, 0);
    chk("rst_u1_ch", c1, 0);
    chk("rst_u1_add", a1, 0);
    chk("rst_u3_req", r3, 0);
    cyc();
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      cyc();
      req4 = 4'hf;
      gnt0 = 1'b1;
      q0.push_back(k % 4);
      @(negedge clk);
      e4 = 4'b0001 << (k % 4);
      chk("fair_gnt", g0, e4);
    end
    cyc();
    req4 = '0;
    gnt0 = 1'b0;

    cyc();
    req4 = 4'b0100;
    @(negedge clk);
    chk("lock_ch_c0", c0, 2);
    chk("lock_gnt_c0", g0, 0);
    chk("lock_add_c0", a0, f_add(2));
    cyc();
    req4 = 4'b0101;
    @(negedge clk);
    chk("lock_ch_c1", c0, 2);
    chk("lock_add_c1", a0, f_add(2));
    cyc();
    @(negedge clk);
    chk("lock_ch_c2", c0, 2);
    chk("lock_gnt_c2", g0, 0);
    cyc();
    gnt0 = 1'b1;
    q0.push_back(2);
    @(negedge clk);
    chk("lock_gnt_rel", g0, 4'b0100);
    cyc();
    q0.push_back(0);
    @(negedge clk);
    chk("lock_next_gnt", g0, 4'b0001);
    cyc();
    req4 = '0;
    gnt0 = 1'b0;

    do_reset();

    cyc();
    req4 = 4'b0010;
    gnt1 = 1'b1;
    q1.push_back(1);
    @(negedge clk);
    chk("b2b_gnt1", g1, 4'b0010);
    chk("b2b_req_lat", r1, 0);
    cyc();
    req4 = 4'b1000;
    q1.push_back(3);
    @(negedge clk);
    chk("b2b_req1", r1, 1);
    chk("b2b_gnt3", g1, 4'b1000);
    cyc();
    req4 = '0;
    @(negedge clk);
    chk("b2b_nobubble", r1, 1);
    cyc();
    @(negedge clk);
    chk("b2b_empty", r1, 0);

    cyc();
    req4 = 4'hf;
    gnt1 = 1'b0;
    q1.push_back(0);
    @(negedge clk);
    chk("stall_first_gnt", g1, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("stall_gnt", g1, 0);
      chk("stall_req", r1, 1);
      chk("stall_ch", c1, 0);
      chk("stall_add", a1, f_add(0));
    end
    cyc();
    gnt1 = 1'b1;
    q1.push_back(1);
    @(negedge clk);
    chk("stall_rel_gnt", g1, 4'b0010);
    cyc();
    req4 = '0;
    @(negedge clk);
    cyc();
    gnt1 = 1'b0;
    @(negedge clk);
    chk("stall_empty", r1, 0);

    cyc();
    req4 = 4'b0100;
    @(negedge clk);
    chk("mrst_gnt", g1, 4'b0100);
    cyc();
    @(negedge clk);
    chk("mrst_req_pre", r1, 1);
    chk("mrst_ch_pre", c1, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_req", r1, 0);
    chk("mrst_ch", c1, 0);
    chk("mrst_add", a1, 0);
    req4 = 4'hf;
    gnt1 = 1'b1;
    #1 rst_n = 1'b1;
    #1;
    chk("mrst_ptr0", g1, 4'b0001);
    q1.push_back(0);
    cyc();
    req4 = '0;
    @(negedge clk);
    cyc();
    gnt1 = 1'b0;

    cyc();
    req3 = 3'b100;
    gnt3 = 1'b1;
    q3.push_back(2);
    @(negedge clk);
    chk("wrap_gnt2", g3, 3'b100);
    cyc();
    req3 = 3'b101;
    q3.push_back(0);
    @(negedge clk);
    chk("wrap_gnt0", g3, 3'b001);
    cyc();
    req3 = 3'b100;
    q3.push_back(2);
    @(negedge clk);
    chk("wrap_gnt2b", g3, 3'b100);
    cyc();
    req3 = '0;
    gnt3 = 1'b0;

    repeat (3) cyc();
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    chk("q3_left", q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
